// File: rtl/datapath_sequencer.sv
// Control sequencer for the 16-bit RISC datapath.
// The machine walks fetch -> decode -> dispatch -> execute and then returns to fetch.
// It drives every datapath strobe and select from the current state, so it is a Moore machine.
// The one exception is the branch PC strobe, which follows Zero_flag.
// It also tracks retired instructions in a saturating counter.
module datapath_sequencer #(
   parameter int unsigned MEM_RD_WAIT = 1,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [6:0]             IR_control,
   input  logic                   Zero_flag,
   output logic                   PC_enable,
   output logic [1:0]             PC_op,
   output logic [1:0]             mux1_sel,
   output logic [1:0]             mux2_sel,
   output logic                   Reg_Write_enable,
   output logic                   IR_enable,
   output logic                   IR_control_enable,
   output logic                   ALU_enable,
   output logic                   Datamem_enable_read,
   output logic                   Datamem_enable_write,
   output logic                   AC_enable,
   output logic                   Zero_flag_enable,
   output logic                   Shifter_enable,
   output logic                   ALU_out_enable,
   output logic                   AR_enable,
   output logic                   halted,
   output logic                   busy,
   output logic [4:0]             state_dbg,
   output logic [COUNT_WIDTH-1:0] instr_count
);

   typedef enum logic [4:0] {
      S_IDLE     = 5'd0,
      S_FETCH    = 5'd1,
      S_FETCH_IR = 5'd2,
      S_DECODE   = 5'd3,
      S_DISPATCH = 5'd4,
      S_ALU_AC   = 5'd5,
      S_ALU_EXEC = 5'd6,
      S_ALU_OUT  = 5'd7,
      S_ALU_WB   = 5'd8,
      S_MEM_ADDR = 5'd9,
      S_MEM_RD   = 5'd10,
      S_MEM_WB   = 5'd11,
      S_MEM_WR   = 5'd12,
      S_IMM_WB   = 5'd13,
      S_JUMP     = 5'd14,
      S_BRANCH   = 5'd15,
      S_HALT     = 5'd16
   } state_t;

   localparam logic [2:0] C_ALU   = 3'b000;
   localparam logic [2:0] C_CMP   = 3'b001;
   localparam logic [2:0] C_LOAD  = 3'b010;
   localparam logic [2:0] C_STORE = 3'b011;
   localparam logic [2:0] C_LOADI = 3'b100;
   localparam logic [2:0] C_JMP   = 3'b101;
   localparam logic [2:0] C_BZ    = 3'b110;

   // Last wait-counter value before leaving MEM_RD.
   localparam logic [3:0] WAIT_LAST = 4'(MEM_RD_WAIT - 1);

   state_t                 state_q, state_d;
   logic [2:0]             class_q, class_d;
   logic [3:0]             wait_q, wait_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   retire;

   // Operand fields of IR_control do not affect sequencing.
   logic unused_ir_low;
   assign unused_ir_low = ^IR_control[3:0];

   // State, latched instruction class, memory wait counter and retire counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         class_q <= 3'b000;
         wait_q  <= 4'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state selection and state-decoded datapath controls.
   always_comb begin
      state_d              = S_IDLE;
      retire               = 1'b0;
      PC_enable            = 1'b0;
      PC_op                = 2'b00;
      mux1_sel             = 2'b00;
      mux2_sel             = 2'b00;
      Reg_Write_enable     = 1'b0;
      IR_enable            = 1'b0;
      IR_control_enable    = 1'b0;
      ALU_enable           = 1'b0;
      Datamem_enable_read  = 1'b0;
      Datamem_enable_write = 1'b0;
      AC_enable            = 1'b0;
      Zero_flag_enable     = 1'b0;
      Shifter_enable       = 1'b0;
      ALU_out_enable       = 1'b0;
      AR_enable            = 1'b0;
      halted               = 1'b0;
      busy                 = 1'b1;

      // The class is held from DISPATCH so later steps of the same instruction can branch on it.
      class_d = (state_q == S_DISPATCH) ? IR_control[6:4] : class_q;
      // The wait counter is zero whenever MEM_RD is entered.
      wait_d  = (state_q == S_MEM_RD) ? wait_q + 4'd1 : 4'd0;

      case (state_q)
         S_IDLE: begin
            busy    = 1'b0;
            state_d = start ? S_FETCH : S_IDLE;
         end
         S_FETCH: state_d = S_FETCH_IR;
         S_FETCH_IR: begin
            IR_enable = 1'b1;
            PC_enable = 1'b1;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            IR_control_enable = 1'b1;
            state_d           = S_DISPATCH;
         end
         S_DISPATCH: begin
            case (IR_control[6:4])
               C_ALU, C_CMP:    state_d = S_ALU_AC;
               C_LOAD, C_STORE: state_d = S_MEM_ADDR;
               C_LOADI:         state_d = S_IMM_WB;
               C_JMP:           state_d = S_JUMP;
               C_BZ:            state_d = S_BRANCH;
               default: begin
                  state_d = S_HALT;
                  retire  = 1'b1;
               end
            endcase
         end
         S_ALU_AC: begin
            AC_enable = 1'b1;
            state_d   = S_ALU_EXEC;
         end
         S_ALU_EXEC: begin
            ALU_enable     = 1'b1;
            Shifter_enable = 1'b1;
            state_d        = S_ALU_OUT;
         end
         S_ALU_OUT: begin
            ALU_out_enable   = 1'b1;
            Zero_flag_enable = 1'b1;
            if (class_q == C_CMP) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end else begin
               state_d = S_ALU_WB;
            end
         end
         S_ALU_WB: begin
            Reg_Write_enable = 1'b1;
            state_d          = S_FETCH;
            retire           = 1'b1;
         end
         S_MEM_ADDR: begin
            mux1_sel  = 2'b10;
            AR_enable = 1'b1;
            state_d   = (class_q == C_STORE) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            Datamem_enable_read = 1'b1;
            state_d = (wait_q == WAIT_LAST) ? S_MEM_WB : S_MEM_RD;
         end
         S_MEM_WB: begin
            mux1_sel         = 2'b01;
            mux2_sel         = 2'b01;
            Reg_Write_enable = 1'b1;
            state_d          = S_FETCH;
            retire           = 1'b1;
         end
         S_MEM_WR: begin
            mux2_sel             = 2'b01;
            Datamem_enable_write = 1'b1;
            state_d              = S_FETCH;
            retire               = 1'b1;
         end
         S_IMM_WB: begin
            mux1_sel         = 2'b10;
            mux2_sel         = 2'b01;
            Reg_Write_enable = 1'b1;
            state_d          = S_FETCH;
            retire           = 1'b1;
         end
         S_JUMP: begin
            mux1_sel  = 2'b10;
            PC_enable = 1'b1;
            PC_op     = 2'b10;
            state_d   = S_FETCH;
            retire    = 1'b1;
         end
         S_BRANCH: begin
            mux1_sel  = 2'b10;
            PC_op     = 2'b01;
            PC_enable = Zero_flag;
            state_d   = S_FETCH;
            retire    = 1'b1;
         end
         S_HALT: begin
            halted  = 1'b1;
            busy    = 1'b0;
            // Resume fetching at the PC already advanced during FETCH_IR.
            state_d = start ? S_FETCH : S_HALT;
         end
         default: begin
            busy    = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      cnt_d = (retire && (cnt_q != '1)) ? cnt_q + COUNT_WIDTH'(1) : cnt_q;
   end

   assign state_dbg   = state_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer.
// Table-driven instruction loops are checked against a scoreboard queue.
// Hand sequences cover halt, asynchronous abort and counter saturation.
module tb_datapath_sequencer;

   logic        clk, reset, start, Zero_flag;
   logic [6:0]  IR_control;
   logic        PC_enable, Reg_Write_enable, IR_enable, IR_control_enable, ALU_enable;
   logic        Datamem_enable_read, Datamem_enable_write, AC_enable, Zero_flag_enable;
   logic        Shifter_enable, ALU_out_enable, AR_enable, halted, busy;
   logic [1:0]  PC_op, mux1_sel, mux2_sel;
   logic [4:0]  state_dbg;
   logic [15:0] instr_count;

   // Second instance with a narrow counter for saturation.
   logic        reset2, start2;
   logic        PC_enable2, Reg_Write_enable2, IR_enable2, IR_control_enable2, ALU_enable2;
   logic        Datamem_enable_read2, Datamem_enable_write2, AC_enable2, Zero_flag_enable2;
   logic        Shifter_enable2, ALU_out_enable2, AR_enable2, halted2, busy2;
   logic [1:0]  PC_op2, mux1_sel2, mux2_sel2;
   logic [4:0]  state_dbg2;
   logic [2:0]  instr_count2;

   datapath_sequencer #(.MEM_RD_WAIT(3), .COUNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .start(start), .IR_control(IR_control), .Zero_flag(Zero_flag),
      .PC_enable(PC_enable), .PC_op(PC_op), .mux1_sel(mux1_sel), .mux2_sel(mux2_sel),
      .Reg_Write_enable(Reg_Write_enable), .IR_enable(IR_enable),
      .IR_control_enable(IR_control_enable), .ALU_enable(ALU_enable),
      .Datamem_enable_read(Datamem_enable_read), .Datamem_enable_write(Datamem_enable_write),
      .AC_enable(AC_enable), .Zero_flag_enable(Zero_flag_enable),
      .Shifter_enable(Shifter_enable), .ALU_out_enable(ALU_out_enable), .AR_enable(AR_enable),
      .halted(halted), .busy(busy), .state_dbg(state_dbg), .instr_count(instr_count)
   );

   datapath_sequencer #(.MEM_RD_WAIT(1), .COUNT_WIDTH(3)) dut2 (
      .clk(clk), .reset(reset2), .start(start2), .IR_control(IR_control), .Zero_flag(Zero_flag),
      .PC_enable(PC_enable2), .PC_op(PC_op2), .mux1_sel(mux1_sel2), .mux2_sel(mux2_sel2),
      .Reg_Write_enable(Reg_Write_enable2), .IR_enable(IR_enable2),
      .IR_control_enable(IR_control_enable2), .ALU_enable(ALU_enable2),
      .Datamem_enable_read(Datamem_enable_read2), .Datamem_enable_write(Datamem_enable_write2),
      .AC_enable(AC_enable2), .Zero_flag_enable(Zero_flag_enable2),
      .Shifter_enable(Shifter_enable2), .ALU_out_enable(ALU_out_enable2), .AR_enable(AR_enable2),
      .halted(halted2), .busy(busy2), .state_dbg(state_dbg2), .instr_count(instr_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed view of all strobes and selects of the main instance.
   logic [17:0] vec;
   always_comb begin
      vec = {PC_enable, PC_op, mux1_sel, mux2_sel, Reg_Write_enable, IR_enable,
             IR_control_enable, ALU_enable, Datamem_enable_read, Datamem_enable_write,
             AC_enable, Zero_flag_enable, Shifter_enable, ALU_out_enable, AR_enable};
   end

   localparam logic [17:0] FIR_VEC = 18'h20200;

   function automatic logic [17:0] ev(logic pcen, logic [1:0] op, logic [1:0] m1,
                                      logic [1:0] m2, logic rw, logic dwr, logic zfe, logic aoe);
      logic [17:0] r;
      r = '0;
      r[17] = pcen; r[16:15] = op; r[14:13] = m1; r[12:11] = m2;
      r[10] = rw; r[5] = dwr; r[3] = zfe; r[1] = aoe;
      return r;
   endfunction

   typedef struct {
      logic [2:0]  cls;
      logic        zf;
      logic        st;
      int          len;
      logic [17:0] last;
      int          rw;
      int          rd;
      int          ar;
   } vec_t;

   vec_t tbl [9];
   vec_t sb [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        e;
      int          n, rw, rd, ar, bad;
      logic [17:0] last, v2;
      logic [15:0] c0;

      tbl[0] = '{3'b000, 1'b0, 1'b0, 8, ev(0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0), 1, 0, 0};
      tbl[1] = '{3'b001, 1'b0, 1'b0, 7, ev(0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 1), 0, 0, 0};
      tbl[2] = '{3'b010, 1'b0, 1'b0, 9, ev(0, 2'b00, 2'b01, 2'b01, 1, 0, 0, 0), 1, 3, 1};
      tbl[3] = '{3'b011, 1'b0, 1'b1, 6, ev(0, 2'b00, 2'b00, 2'b01, 0, 1, 0, 0), 0, 0, 1};
      tbl[4] = '{3'b100, 1'b0, 1'b0, 5, ev(0, 2'b00, 2'b10, 2'b01, 1, 0, 0, 0), 1, 0, 0};
      tbl[5] = '{3'b101, 1'b0, 1'b0, 5, ev(1, 2'b10, 2'b10, 2'b00, 0, 0, 0, 0), 0, 0, 0};
      tbl[6] = '{3'b110, 1'b1, 1'b0, 5, ev(1, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0), 0, 0, 0};
      tbl[7] = '{3'b110, 1'b0, 1'b1, 5, ev(0, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0), 0, 0, 0};
      tbl[8] = '{3'b000, 1'b1, 1'b0, 8, ev(0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0), 1, 0, 0};

      reset = 1'b0; reset2 = 1'b0; start = 1'b0; start2 = 1'b0;
      IR_control = 7'd0; Zero_flag = 1'b0;
      repeat (3) tick();
      chk("reset_vec", 32'(vec), 0);
      chk("reset_state", 32'(state_dbg), 0);
      chk("reset_count", 32'(instr_count), 0);
      chk("reset_halted_busy", {30'd0, halted, busy}, 0);

      reset = 1'b1;
      tick();
      chk("idle_hold", 32'(state_dbg), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_to_fetch", 32'(state_dbg), 1);

      // Instruction loops; each begins with the DUT in FETCH.
      for (int i = 0; i < 9; i++) begin
         IR_control = {tbl[i].cls, 4'($urandom_range(0, 15))};
         Zero_flag  = tbl[i].zf;
         start      = tbl[i].st;
         sb.push_back(tbl[i]);
         c0 = instr_count;
         n = 1; rw = 0; rd = 0; ar = 0; last = '0; v2 = '0;
         forever begin
            tick();
            n++;
            if (n == 2) v2 = vec;
            if (state_dbg == 5'd1 || n > 40) break;
            last = vec;
            rw += int'(Reg_Write_enable);
            rd += int'(Datamem_enable_read);
            ar += int'(AR_enable);
         end
         start = 1'b0;
         e = sb.pop_front();
         chk($sformatf("v%0d_len", i), n - 1, e.len);
         chk($sformatf("v%0d_fetch_ir", i), 32'(v2), 32'(FIR_VEC));
         chk($sformatf("v%0d_last", i), 32'(last), 32'(e.last));
         chk($sformatf("v%0d_rw", i), rw, e.rw);
         chk($sformatf("v%0d_rd", i), rd, e.rd);
         chk($sformatf("v%0d_ar", i), ar, e.ar);
         chk($sformatf("v%0d_count", i), 32'(instr_count - c0), 1);
      end

      // HALT instruction: retires on entry, stays quiet, resumes on start.
      IR_control = {3'b111, 4'b0101};
      c0 = instr_count;
      repeat (4) tick();
      chk("halt_state", 32'(state_dbg), 16);
      chk("halt_count", 32'(instr_count), 32'(c0) + 1);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (halted !== 1'b1 || busy !== 1'b0 || vec !== '0 || state_dbg !== 5'd16) bad++;
         tick();
      end
      chk("halt_quiet", bad, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("halt_resume", 32'(state_dbg), 1);
      chk("resume_no_retire", 32'(instr_count), 32'(c0) + 1);

      // Abort in ALU_EXEC with the asynchronous reset.
      IR_control = {3'b000, 4'b1111};
      n = 0;
      while (state_dbg != 5'd6 && n < 20) begin
         tick();
         n++;
      end
      chk("reach_alu_exec", 32'(state_dbg), 6);
      reset = 1'b0;
      #1;
      chk("abort_vec", 32'(vec), 0);
      chk("abort_state", 32'(state_dbg), 0);
      chk("abort_count", 32'(instr_count), 0);
      tick();
      reset = 1'b1;
      bad = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (Reg_Write_enable !== 1'b0 || state_dbg !== 5'd0) bad++;
      end
      chk("abort_no_writeback", bad, 0);

      // Saturation: a 3-bit counter driven past 7 retirements must stick at 7.
      IR_control = {3'b100, 4'b0000};
      reset2 = 1'b1;
      tick();
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      repeat (30) tick();
      chk("count_before_sat", 32'(instr_count2), 6);
      repeat (40) tick();
      chk("count_saturated", 32'(instr_count2), 7);
      chk("sat_still_busy", 32'(busy2), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Moore-style control FSM that sequences the 16-bit RISC datapath: fetch, decode, execute, writeback. It drives every enable/select input of the datapath and consumes the decoded instruction class (IR_control) and Zero_flag. It also provides run control (start/halt) and a retired-instruction counter.

Parameters:
MEM_RD_WAIT, 1, cycles spent in MEM_RD (legal 1..15)
COUNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  leave IDLE or HALT and begin fetching
IR_control  in  7  decoded instruction from IR; [6:4] = class, [3:0] ignored
Zero_flag  in  1  datapath zero flag
PC_enable  out  1  PC update strobe
PC_op  out  2  00 increment, 01 add offset (Databus1), 10 load absolute
mux1_sel  out  2  00 Reg read 1, 01 data memory, 10 IR immediate, 11 zero
mux2_sel  out  2  00 ALU_out, 01 Databus1, 10 zero, 11 all-ones
Reg_Write_enable, IR_enable, IR_control_enable, ALU_enable, Datamem_enable_read, Datamem_enable_write, AC_enable, Zero_flag_enable, Shifter_enable, ALU_out_enable, AR_enable  out  1 each  datapath strobes
halted  out  1  FSM in HALT
busy  out  1  FSM in neither IDLE nor HALT
state_dbg  out  5  current state encoding
instr_count  out  COUNT_WIDTH  retired instructions, saturating

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, instr_count=0. All outputs 0, including selects and PC_op.
- Outputs are a pure function of state, plus Zero_flag in BRANCH. Any strobe not listed for a state is 0. Selects not listed are 00.
- Instruction classes (IR_control[6:4]): 000 ALU, 001 CMP, 010 LOAD, 011 STORE, 100 LOADI, 101 JMP, 110 BZ, 111 HALT.
- IDLE: all outputs 0. start=1 moves to FETCH.
- FETCH: no strobes; allows one cycle for I_memory read. Next state FETCH_IR.
- FETCH_IR: IR_enable=1, PC_enable=1, PC_op=00. Next state DECODE.
- DECODE: IR_control_enable=1. Next state DISPATCH.
- DISPATCH: no strobes. Branches on the class sampled this cycle:
  - ALU/CMP -> ALU_AC
  - LOAD/STORE -> MEM_ADDR
  - LOADI -> IMM_WB
  - JMP -> JUMP
  - BZ -> BRANCH
  - HALT -> HALT
- ALU_AC: AC_enable=1. Next state ALU_EXEC.
- ALU_EXEC: ALU_enable=1, Shifter_enable=1, mux1_sel=00. Next state ALU_OUT.
- ALU_OUT: ALU_out_enable=1, Zero_flag_enable=1. Next state is ALU_WB for ALU, FETCH for CMP (class held from DISPATCH).
- ALU_WB: mux2_sel=00, Reg_Write_enable=1. Next state FETCH.
- MEM_ADDR: mux1_sel=10, AR_enable=1. Next state MEM_RD for LOAD, MEM_WR for STORE.
- MEM_RD: Datamem_enable_read=1 for exactly MEM_RD_WAIT cycles, counted by a 4-bit wait counter cleared on entry. Next state MEM_WB.
- MEM_WB: mux1_sel=01, mux2_sel=01, Reg_Write_enable=1. Next state FETCH.
- MEM_WR: mux1_sel=00, mux2_sel=01, Datamem_enable_write=1. Next state FETCH.
- IMM_WB: mux1_sel=10, mux2_sel=01, Reg_Write_enable=1. Next state FETCH.
- JUMP: mux1_sel=10, PC_enable=1, PC_op=10. Next state FETCH.
- BRANCH: mux1_sel=10, PC_op=01, PC_enable=Zero_flag (sampled this cycle). Next state FETCH.
- HALT: halted=1, all strobes 0. start=1 moves to FETCH and resumes at the already-incremented PC.
- Latency (cycles from FETCH entry back to FETCH entry): ALU 8, CMP 7, LOAD 6+MEM_RD_WAIT, STORE 6, LOADI/JMP/BZ 5.
- Retirement: instr_count increments by 1 on every transition into FETCH from an execute state, and on entry to HALT. It saturates at all-ones; no wrap.
- start is ignored outside IDLE/HALT.
- Reset asserted mid-instruction aborts immediately to IDLE with all outputs 0 in the same cycle; there is no partial writeback after release.
- Unreachable state encodings recover to IDLE on the next clock.

Test Plan:
- reset=0 mid-ALU_EXEC -> all outputs 0 and state_dbg=IDLE immediately; instr_count=0; no Reg_Write_enable pulse after release.
- start pulse with IR_control=7'b000_xxxx -> FETCH_IR at cycle 2 (IR_enable=PC_enable=1, PC_op=00), Reg_Write_enable=1 with mux2_sel=00 at cycle 8, instr_count=1.
- CMP class -> Zero_flag_enable=1 at cycle 7, Reg_Write_enable never asserted, back in FETCH at cycle 8.
- LOAD with MEM_RD_WAIT=3 -> AR_enable at cycle 5, Datamem_enable_read high for exactly 3 cycles, MEM_WB with mux1_sel=01/mux2_sel=01; loop length 9. STORE -> Datamem_enable_write with mux1_sel=00, loop length 6.
- BZ with Zero_flag=1 -> PC_enable=1, PC_op=01; with Zero_flag=0 -> PC_enable=0. JMP -> PC_op=10, PC_enable=1.
- HALT class -> halted=1, busy=0, strobes quiet for 20 cycles; start -> FETCH next cycle. Force instr_count to 0xFFFF, retire one more -> remains 0xFFFF.
